// File: rtl/ps2_key_decoder_if.sv
// Bundle of PS/2 pins and the held-key map published by ps2_key_decoder.
// The slave modport is the decoder. The master modport is the pin driver and the map consumer.
interface ps2_key_decoder_if;
    logic         ps2_clk;
    logic         ps2_data;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         been_ready;
    logic         frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_down,
        output last_change,
        output been_ready,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_down,
        input  last_change,
        input  been_ready,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver. It deserialises frames and folds the E0/F0 prefixes into 9-bit codes.
// It also maintains the 512-entry held-key map.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    ps2_key_decoder_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [511:0]     key_down_q, key_down_d;
    logic [8:0]       last_change_q, last_change_d;
    logic             been_ready_q, been_ready_d;

    logic             fall;
    logic             ps2_bit;
    logic [7:0]       rx_byte;
    logic [8:0]       rx_code;
    logic             frame_ok;
    logic             byte_valid;
    logic             frame_err;

    // clk_sync_q[1] is the synchronised pin and clk_sync_q[2] is its previous value.
    assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
    assign ps2_bit    = data_sync_q[1];
    assign rx_byte    = shift_q[7:0];
    assign rx_code    = {ext_q, rx_byte};
    assign frame_ok   = (^shift_q[8:0]) & shift_q[9];
    assign byte_valid = (state_q == CHECK) &  frame_ok;
    assign frame_err  = (state_q == CHECK) & ~frame_ok;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], bus.ps2_clk};
        data_sync_d = {data_sync_q[0], bus.ps2_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        idle_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (fall && !ps2_bit) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            RECV: begin
                // Bits arrive LSB first, so after ten shifts the data byte sits in shift_q[7:0].
                if (fall) begin
                    shift_d   = {ps2_bit, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = CHECK;
                    end
                end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        been_ready_d  = 1'b0;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            case (rx_byte)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hE1: ;
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    key_down_d[rx_code] = ~brk_q;
                    last_change_d       = rx_code;
                    been_ready_d        = 1'b1;
                    ext_d               = 1'b0;
                    brk_d               = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            idle_cnt_q    <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_down_q    <= '0;
            last_change_q <= '0;
            been_ready_q  <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            idle_cnt_q    <= idle_cnt_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            been_ready_q  <= been_ready_d;
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.last_change = last_change_q;
    assign bus.been_ready  = been_ready_q;
    assign bus.frame_err   = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder. A spec-level scancode model pushes expected events to a queue.
// A negedge monitor pops them on every been_ready pulse.
module tb_ps2_key_decoder;

    localparam int TO = 200;
    localparam int HP = 20;

    typedef struct {
        logic [8:0] code;
        logic       down;
    } event_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ps2_key_decoder_if bus_if ();

    ps2_key_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           br_seen = 0;
    int           fe_seen = 0;
    int           fe_expected = 0;
    logic         br_prev = 1'b0;
    event_t       exp_q[$];
    logic [511:0] key_model = '0;
    logic         m_ext = 1'b0;
    logic         m_brk = 1'b0;

    // Every been_ready pulse must match the oldest expected event and must last one cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            br_prev = 1'b0;
        end else begin
            if (bus_if.frame_err) fe_seen++;
            if (bus_if.been_ready) begin
                br_seen++;
                n_checks++;
                if (br_prev !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL been_ready_width: high on consecutive cycles, required single-cycle pulse");
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: last_change=%h, required no event", bus_if.last_change);
                end else begin
                    event_t e;
                    e = exp_q.pop_front();
                    if (bus_if.last_change !== e.code) begin
                        n_fail++;
                        $display("[TB] FAIL event_code: got %h, required %h", bus_if.last_change, e.code);
                    end
                    n_checks++;
                    if (bus_if.key_down[e.code] !== e.down) begin
                        n_fail++;
                        $display("[TB] FAIL event_key_state: key_down[%h]=%b, required %b",
                                 e.code, bus_if.key_down[e.code], e.down);
                    end
                end
            end
            br_prev = bus_if.been_ready;
        end
    end

    initial begin
        #(600000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [8:0] code;
        case (b)
            8'hE0: m_ext = 1'b1;
            8'hF0: m_brk = 1'b1;
            8'hE1: ;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            default: begin
                code = {m_ext, b};
                key_model[code] = ~m_brk;
                exp_q.push_back('{code: code, down: ~m_brk});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        endcase
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus_if.ps2_data = bits[i];
            repeat (HP) @(posedge clk);
            #1 bus_if.ps2_clk = 1'b0;
            repeat (HP) @(posedge clk);
            #1 bus_if.ps2_clk = 1'b1;
        end
    endtask

    task automatic wait_idle();
        repeat (3 * HP) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL pending_events: %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_bits(make_frame(b, 1'b0), 0, 10);
        wait_idle();
    endtask

    task automatic send_bad(input logic [7:0] b);
        fe_expected++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_bits(make_frame(b, 1'b1), 0, 10);
        wait_idle();
    endtask

    task automatic check_map(input string name);
        n_checks++;
        if (bus_if.key_down !== key_model) begin
            n_fail++;
            $display("[TB] FAIL %s: key_down=%h required %h", name, bus_if.key_down, key_model);
        end
    endtask

    task automatic test_reset();
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (bus_if.key_down !== '0) begin
            n_fail++; $display("[TB] FAIL reset_key_down: got %h, required 0", bus_if.key_down);
        end
        if (bus_if.last_change !== 9'h000) begin
            n_fail++; $display("[TB] FAIL reset_last_change: got %h, required 000", bus_if.last_change);
        end
        if (bus_if.been_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_been_ready: got %b, required 0", bus_if.been_ready);
        end
        if (bus_if.frame_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_frame_err: got %b, required 0", bus_if.frame_err);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    // The stop bit is sent by hand so the pin-edge-to-been_ready latency can be measured.
    task automatic test_make_w();
        logic [10:0] f;
        int          fe0;
        int          lat;
        fe0 = fe_seen;
        f = make_frame(8'h1D, 1'b0);
        model_byte(8'h1D);
        send_bits(f, 0, 9);
        bus_if.ps2_data = 1'b1;
        repeat (HP) @(posedge clk);
        #1 bus_if.ps2_clk = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_if.been_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 5) begin
            n_fail++; $display("[TB] FAIL make_latency: been_ready after %0d cycles, required 5", lat);
        end
        repeat (HP) @(posedge clk);
        #1 bus_if.ps2_clk = 1'b1;
        wait_idle();
        n_checks += 3;
        if (bus_if.key_down[9'h01D] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL make_key: got %b, required 1", bus_if.key_down[9'h01D]);
        end
        if (bus_if.last_change !== 9'h01D) begin
            n_fail++; $display("[TB] FAIL make_last: got %h, required 01D", bus_if.last_change);
        end
        if (fe_seen != fe0) begin
            n_fail++; $display("[TB] FAIL make_frame_err: %0d pulses, required 0", fe_seen - fe0);
        end
    endtask

    task automatic test_break_w();
        int br0;
        br0 = br_seen;
        send_byte(8'hF0);
        send_byte(8'h1D);
        n_checks += 3;
        if (br_seen - br0 != 1) begin
            n_fail++; $display("[TB] FAIL break_pulses: got %0d, required 1", br_seen - br0);
        end
        if (bus_if.key_down[9'h01D] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL break_key: got %b, required 0", bus_if.key_down[9'h01D]);
        end
        if (bus_if.last_change !== 9'h01D) begin
            n_fail++; $display("[TB] FAIL break_last: got %h, required 01D", bus_if.last_change);
        end
    endtask

    task automatic test_extended();
        int br0;
        br0 = br_seen;
        send_byte(8'hE0);
        send_byte(8'h75);
        n_checks += 2;
        if (bus_if.key_down[9'h175] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ext_make_key: got %b, required 1", bus_if.key_down[9'h175]);
        end
        if (bus_if.last_change !== 9'h175) begin
            n_fail++; $display("[TB] FAIL ext_make_last: got %h, required 175", bus_if.last_change);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_checks += 3;
        if (bus_if.key_down[9'h175] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ext_break_key: got %b, required 0", bus_if.key_down[9'h175]);
        end
        if (bus_if.key_down[9'h075] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ext_plain_key: got %b, required 0", bus_if.key_down[9'h075]);
        end
        if (br_seen - br0 != 2) begin
            n_fail++; $display("[TB] FAIL ext_pulses: got %0d, required 2", br_seen - br0);
        end
    endtask

    task automatic test_parity_error();
        int br0;
        int fe0;
        br0 = br_seen;
        fe0 = fe_seen;
        send_byte(8'hE0);
        send_bad(8'h1D);
        n_checks += 2;
        if (fe_seen - fe0 != 1) begin
            n_fail++; $display("[TB] FAIL parity_err_pulses: got %0d, required 1", fe_seen - fe0);
        end
        if (br_seen != br0) begin
            n_fail++; $display("[TB] FAIL parity_no_event: got %0d pulses, required 0", br_seen - br0);
        end
        check_map("parity_map");
        send_byte(8'h1D);
        n_checks++;
        if (bus_if.last_change !== 9'h01D) begin
            n_fail++; $display("[TB] FAIL parity_recover: got %h, required 01D", bus_if.last_change);
        end
    endtask

    task automatic test_dropped_and_repeat();
        int br0;
        send_byte(8'hE0);
        send_byte(8'hAA);
        send_byte(8'h1D);
        send_byte(8'hE0);
        send_byte(8'hE1);
        send_byte(8'h75);
        n_checks++;
        if (bus_if.last_change !== 9'h175) begin
            n_fail++; $display("[TB] FAIL e1_keeps_ext: got %h, required 175", bus_if.last_change);
        end
        br0 = br_seen;
        send_byte(8'h1C);
        send_byte(8'h1C);
        n_checks += 2;
        if (br_seen - br0 != 2) begin
            n_fail++; $display("[TB] FAIL repeat_pulses: got %0d, required 2", br_seen - br0);
        end
        if (bus_if.key_down[9'h01C] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL repeat_key: got %b, required 1", bus_if.key_down[9'h01C]);
        end
        check_map("dropped_map");
    endtask

    task automatic test_timeout();
        int br0;
        int fe0;
        br0 = br_seen;
        fe0 = fe_seen;
        send_bits(make_frame(8'h1C, 1'b0), 0, 4);
        repeat (TO + 10) @(posedge clk);
        send_byte(8'h1C);
        n_checks += 3;
        if (bus_if.last_change !== 9'h01C) begin
            n_fail++; $display("[TB] FAIL timeout_last: got %h, required 01C", bus_if.last_change);
        end
        if (br_seen - br0 != 1) begin
            n_fail++; $display("[TB] FAIL timeout_pulses: got %0d, required 1", br_seen - br0);
        end
        if (fe_seen != fe0) begin
            n_fail++; $display("[TB] FAIL timeout_frame_err: %0d pulses, required 0", fe_seen - fe0);
        end
    endtask

    task automatic test_chord_and_reset();
        logic [10:0] f;
        send_byte(8'h1D);
        send_byte(8'h23);
        n_checks++;
        if (bus_if.key_down[9'h01D] !== 1'b1 || bus_if.key_down[9'h023] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL chord_keys: 01D=%b 023=%b, required 1 1",
                               bus_if.key_down[9'h01D], bus_if.key_down[9'h023]);
        end
        check_map("chord_map");
        f = make_frame(8'h23, 1'b0);
        send_bits(f, 0, 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus_if.key_down !== '0) begin
            n_fail++; $display("[TB] FAIL midreset_key_down: got %h, required 0", bus_if.key_down);
        end
        if (bus_if.last_change !== 9'h000) begin
            n_fail++; $display("[TB] FAIL midreset_last: got %h, required 000", bus_if.last_change);
        end
        if (bus_if.been_ready !== 1'b0 || bus_if.frame_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset_strobes: been_ready=%b frame_err=%b, required 0 0",
                               bus_if.been_ready, bus_if.frame_err);
        end
        key_model = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send_bits(f, 5, 10);
        repeat (TO + 10) @(posedge clk);
        send_byte(8'h1B);
        n_checks++;
        if (bus_if.last_change !== 9'h01B) begin
            n_fail++; $display("[TB] FAIL postreset_last: got %h, required 01B", bus_if.last_change);
        end
        check_map("postreset_map");
    endtask

    initial begin
        test_reset();
        test_make_w();
        test_break_w();
        test_extended();
        test_parity_error();
        test_dropped_and_repeat();
        test_timeout();
        test_chord_and_reset();
        n_checks++;
        if (fe_seen != fe_expected) begin
            n_fail++; $display("[TB] FAIL frame_err_total: got %0d, required %0d", fe_seen, fe_expected);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
